crh_banked: RTL and testbench

- Parametrised successor to the single-table CRH counting filter: a table of 2^REGION_WIDTH saturating counters indexed by the top address bits.
- Same-cycle increment, decrement and probe are supported, with hazard forwarding, a self-clearing init/clear sweep, sticky saturation flags and a valid-qualified probe result.
- Sits beside the processor's memory-reference tracking. Its result feeds filter decisions, where p_empty=1 means no tracked reference exists in the region.

---
 rtl/crh_pkg.sv | 23 ++
 rtl/crh_counter_ram.sv | 44 ++++
 rtl/crh_banked.sv | 194 +++++++++++++++++++
 tb/tb_crh_banked.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/crh_pkg.sv
// rtl/crh_pkg.sv - shared defaults, FSM state type and region extraction for the CRH counting filter
//
// Contents:
//   REGION_WIDTH_DEF / COUNT_WIDTH_DEF : default table geometry
//   crh_state_t                        : INIT (zeroing sweep) / RUN (ops accepted)
//   region_of()                        : top region_width bits of an address, right-aligned

package crh_pkg;

    localparam int REGION_WIDTH_DEF = 11;
    localparam int COUNT_WIDTH_DEF  = 16;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } crh_state_t;

    // Callers size-cast the result down to their own region width.
    function automatic logic [31:0] region_of(input logic [31:0] address, input int region_width);
        return address >> (32 - region_width);
    endfunction

endpackage

// File: rtl/crh_counter_ram.sv
// rtl/crh_counter_ram.sv - counter table with three synchronous read ports and two write ports
//
// Ports:
//   clock                         : rising-edge clock
//   inc/dec/probe_raddr, _rdata   : synchronous read ports, data one cycle after address
//   inc/dec_we, _waddr, _wdata    : write ports
// Reads return the contents before any write on the same edge (read-before-write);
// the caller forwards the freshest values. The two write ports never target the
// same address in one cycle.

module crh_counter_ram #(
    parameter int AW = 11,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic [AW-1:0] inc_raddr,
    input  logic [AW-1:0] dec_raddr,
    input  logic [AW-1:0] probe_raddr,
    output logic [DW-1:0] inc_rdata,
    output logic [DW-1:0] dec_rdata,
    output logic [DW-1:0] probe_rdata,
    input  logic          inc_we,
    input  logic [AW-1:0] inc_waddr,
    input  logic [DW-1:0] inc_wdata,
    input  logic          dec_we,
    input  logic [AW-1:0] dec_waddr,
    input  logic [DW-1:0] dec_wdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clock) begin
        inc_rdata   <= mem[inc_raddr];
        dec_rdata   <= mem[dec_raddr];
        probe_rdata <= mem[probe_raddr];
        if (inc_we) begin
            mem[inc_waddr] <= inc_wdata;
        end
        if (dec_we) begin
            mem[dec_waddr] <= dec_wdata;
        end
    end

endmodule

// File: rtl/crh_banked.sv
// rtl/crh_banked.sv - banked CRH counting filter: saturating per-region counters with probe
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   clear               : pulse, restarts the zeroing sweep and clears the sticky flags
//   ready               : 1 when inc/dec/probe are accepted this cycle
//   increment, _address : increment request and address
//   decrement, _address : decrement request and address
//   probe, _address     : probe request and address
//   p_valid             : one-cycle strobe, result of the probe accepted two cycles earlier
//   p_empty, p_count    : probed counter == 0, probed counter value (held between strobes)
//   overflow, underflow : sticky saturation flags
//
// Pipeline: stage 0 presents addresses to the RAM; stage 1 merges the RAM read with
// the writes made on the previous edge (which the read-before-write RAM missed),
// applies the saturating update and writes it back, or registers the probe result.

module crh_banked
    import crh_pkg::*;
#(
    parameter int REGION_WIDTH    = REGION_WIDTH_DEF,
    parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF,
    parameter int PROBE_COUNT_OUT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   ready,
    input  logic                   increment,
    input  logic [31:0]            increment_address,
    input  logic                   decrement,
    input  logic [31:0]            decrement_address,
    input  logic                   probe,
    input  logic [31:0]            probe_address,
    output logic                   p_valid,
    output logic                   p_empty,
    output logic [COUNT_WIDTH-1:0] p_count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [COUNT_WIDTH-1:0]  CMAX = '1;
    localparam logic [COUNT_WIDTH-1:0]  ONE  = COUNT_WIDTH'(1);
    localparam logic [REGION_WIDTH-1:0] LAST = '1;

    crh_state_t              state;
    logic [REGION_WIDTH-1:0] sweep_addr;

    logic [REGION_WIDTH-1:0] inc_region, dec_region, probe_region;
    logic                    kill;

    logic                    s1_inc, s1_dec, s1_probe;
    logic [REGION_WIDTH-1:0] s1_inc_region, s1_dec_region, s1_probe_region;

    // Copies of the writes made on the last edge.
    logic                    f_inc_we, f_dec_we;
    logic [REGION_WIDTH-1:0] f_inc_region, f_dec_region;
    logic [COUNT_WIDTH-1:0]  f_inc_data, f_dec_data;

    logic [COUNT_WIDTH-1:0]  inc_rdata, dec_rdata, probe_rdata;
    logic [COUNT_WIDTH-1:0]  cur_inc, cur_dec, cur_probe;
    logic                    same_region, inc_we_run, dec_we_run, set_ovf, set_unf;
    logic                    ram_inc_we, ram_dec_we;
    logic [REGION_WIDTH-1:0] ram_inc_waddr;
    logic [COUNT_WIDTH-1:0]  ram_inc_wdata;
    logic [COUNT_WIDTH-1:0]  p_count_r;

    assign ready        = (state == RUN);
    assign kill         = reset | clear;
    assign inc_region   = REGION_WIDTH'(region_of(increment_address, REGION_WIDTH));
    assign dec_region   = REGION_WIDTH'(region_of(decrement_address, REGION_WIDTH));
    assign probe_region = REGION_WIDTH'(region_of(probe_address, REGION_WIDTH));
    assign p_count      = (PROBE_COUNT_OUT != 0) ? p_count_r : '0;

    // Inc and dec never write the same region in one cycle, so at most one source matches.
    function automatic logic [COUNT_WIDTH-1:0] fwd_value(input logic [REGION_WIDTH-1:0] region,
                                                         input logic [COUNT_WIDTH-1:0]  ram_value);
        if (f_inc_we && f_inc_region == region) begin
            return f_inc_data;
        end
        if (f_dec_we && f_dec_region == region) begin
            return f_dec_data;
        end
        return ram_value;
    endfunction

    always_comb begin
        cur_inc     = fwd_value(s1_inc_region, inc_rdata);
        cur_dec     = fwd_value(s1_dec_region, dec_rdata);
        cur_probe   = fwd_value(s1_probe_region, probe_rdata);
        // Opposite ops on one region cancel: no write, no flag, even when saturated.
        same_region = s1_inc && s1_dec && (s1_inc_region == s1_dec_region);
        inc_we_run  = s1_inc && !same_region && (cur_inc != CMAX);
        set_ovf     = s1_inc && !same_region && (cur_inc == CMAX);
        // A counter at CMAX has lost track of its true count and stays pinned.
        dec_we_run  = s1_dec && !same_region && (cur_dec != CMAX) && (cur_dec != '0);
        set_unf     = s1_dec && !same_region && (cur_dec == '0);

        if (state == INIT) begin
            ram_inc_we    = 1'b1;
            ram_inc_waddr = sweep_addr;
            ram_inc_wdata = '0;
            ram_dec_we    = 1'b0;
        end else begin
            ram_inc_we    = inc_we_run && !kill;
            ram_inc_waddr = s1_inc_region;
            ram_inc_wdata = cur_inc + ONE;
            ram_dec_we    = dec_we_run && !kill;
        end
    end

    crh_counter_ram #(
        .AW (REGION_WIDTH),
        .DW (COUNT_WIDTH)
    ) u_ram (
        .clock       (clock),
        .inc_raddr   (inc_region),
        .dec_raddr   (dec_region),
        .probe_raddr (probe_region),
        .inc_rdata   (inc_rdata),
        .dec_rdata   (dec_rdata),
        .probe_rdata (probe_rdata),
        .inc_we      (ram_inc_we),
        .inc_waddr   (ram_inc_waddr),
        .inc_wdata   (ram_inc_wdata),
        .dec_we      (ram_dec_we),
        .dec_waddr   (s1_dec_region),
        .dec_wdata   (cur_dec - ONE)
    );

    always_ff @(posedge clock) begin
        if (kill) begin
            state      <= INIT;
            sweep_addr <= '0;
        end else if (state == INIT) begin
            sweep_addr <= sweep_addr + REGION_WIDTH'(1);
            if (sweep_addr == LAST) begin
                state <= RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (kill) begin
            s1_inc   <= 1'b0;
            s1_dec   <= 1'b0;
            s1_probe <= 1'b0;
            f_inc_we <= 1'b0;
            f_dec_we <= 1'b0;
        end else begin
            s1_inc   <= ready && increment;
            s1_dec   <= ready && decrement;
            s1_probe <= ready && probe;
            f_inc_we <= ready && inc_we_run;
            f_dec_we <= ready && dec_we_run;
        end
        s1_inc_region   <= inc_region;
        s1_dec_region   <= dec_region;
        s1_probe_region <= probe_region;
        f_inc_region    <= s1_inc_region;
        f_dec_region    <= s1_dec_region;
        f_inc_data      <= cur_inc + ONE;
        f_dec_data      <= cur_dec - ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_valid   <= 1'b0;
            p_empty   <= 1'b0;
            p_count_r <= '0;
        end else begin
            p_valid <= s1_probe && !clear;
            if (s1_probe && !clear) begin
                p_empty   <= (cur_probe == '0);
                p_count_r <= cur_probe;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (kill) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_ovf) begin
                overflow <= 1'b1;
            end
            if (set_unf) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crh_banked.sv
// tb/tb_crh_banked.sv - self-checking bench for crh_banked (16-bit and 2-bit counter builds side by side)

module tb_crh_banked;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        increment = 1'b0;
    logic [31:0] increment_address = '0;
    logic        decrement = 1'b0;
    logic [31:0] decrement_address = '0;
    logic        probe = 1'b0;
    logic [31:0] probe_address = '0;

    logic        a_ready, a_p_valid, a_p_empty, a_overflow, a_underflow;
    logic [15:0] a_p_count;
    logic        b_ready, b_p_valid, b_p_empty, b_overflow, b_underflow;
    logic [1:0]  b_p_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    crh_banked #(.REGION_WIDTH(11), .COUNT_WIDTH(16), .PROBE_COUNT_OUT(1)) dut_a (
        .clock(clock), .reset(reset), .clear(clear), .ready(a_ready),
        .increment(increment), .increment_address(increment_address),
        .decrement(decrement), .decrement_address(decrement_address),
        .probe(probe), .probe_address(probe_address),
        .p_valid(a_p_valid), .p_empty(a_p_empty), .p_count(a_p_count),
        .overflow(a_overflow), .underflow(a_underflow)
    );

    crh_banked #(.REGION_WIDTH(11), .COUNT_WIDTH(2), .PROBE_COUNT_OUT(1)) dut_b (
        .clock(clock), .reset(reset), .clear(clear), .ready(b_ready),
        .increment(increment), .increment_address(increment_address),
        .decrement(decrement), .decrement_address(decrement_address),
        .probe(probe), .probe_address(probe_address),
        .p_valid(b_p_valid), .p_empty(b_p_empty), .p_count(b_p_count),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    typedef struct {
        logic        inc;
        logic [31:0] ia;
        logic        dec;
        logic [31:0] da;
        logic        prb;
        logic [31:0] pa;
        int          e16;
        int          e2;
    } vec_t;

    typedef struct {
        int e16;
        int e2;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] raddr(input int r);
        return 32'(r) << 21;
    endfunction

    function automatic vec_t mk(input logic inc, input logic [31:0] ia, input logic dec,
                                input logic [31:0] da, input logic prb, input logic [31:0] pa,
                                input int e16, input int e2);
        vec_t v;
        v.inc = inc; v.ia = ia; v.dec = dec; v.da = da;
        v.prb = prb; v.pa = pa; v.e16 = e16; v.e2 = e2;
        return v;
    endfunction

    // Scoreboard: every p_valid pops one expectation pushed when the probe was driven.
    always @(negedge clock) begin
        if (a_p_valid || b_p_valid) begin
            check("p_valid agreement", 32'(b_p_valid), 32'(a_p_valid));
            if (sbq.size() == 0) begin
                check("unexpected p_valid", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("p_count w16", 32'(a_p_count), 32'(e.e16));
                check("p_empty w16", 32'(a_p_empty), 32'(e.e16 == 0));
                check("p_count w2", 32'(b_p_count), 32'(e.e2));
                check("p_empty w2", 32'(b_p_empty), 32'(e.e2 == 0));
            end
        end
    end

    // Counts consecutive not-ready cycles (sampled at negedge) and notes any p_valid seen.
    task automatic count_not_ready(output int n, output logic pv_seen);
        n = 0;
        pv_seen = 1'b0;
        @(negedge clock);
        while (!a_ready && n < 5000) begin
            n++;
            if (a_p_valid || b_p_valid) pv_seen = 1'b1;
            @(negedge clock);
        end
    endtask

    task automatic drive_idle();
        increment = 1'b0; decrement = 1'b0; probe = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        logic pv;

        vecs[0]  = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
        vecs[1]  = mk(1, 32'h0010_0000, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 32'h0010_0000, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 32'h0010_0000, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1, 32'h0010_0000, 3, 3);
        vecs[5]  = mk(0, 0, 1, 32'h0010_0000, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 32'h0010_0000, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 1, 32'h0010_0000, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 32'h0010_0000, 0, 3);
        vecs[9]  = mk(1, 32'h0020_0000, 1, 32'h0020_0000, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0, 1, 32'h0020_0000, 0, 0);
        vecs[11] = mk(1, raddr(4), 1, raddr(5), 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 1, raddr(4), 1, 1);
        vecs[13] = mk(0, 0, 0, 0, 1, raddr(5), 0, 0);
        vecs[14] = mk(1, raddr(7), 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, raddr(7), 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(1, raddr(7), 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, raddr(7), 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, raddr(7), 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 1, raddr(7), 3, 3);
        vecs[20] = mk(1, raddr(9), 0, 0, 1, raddr(9), 0, 0);
        vecs[21] = mk(1, raddr(9), 0, 0, 1, raddr(9), 1, 1);
        vecs[22] = mk(0, 0, 0, 0, 1, raddr(9), 2, 2);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset ready", 32'(a_ready), 0);
        check("reset p_valid", 32'(a_p_valid), 0);
        check("reset p_empty", 32'(a_p_empty), 0);
        check("reset p_count", 32'(a_p_count), 0);
        check("reset overflow", 32'(a_overflow), 0);
        check("reset underflow", 32'(a_underflow), 0);
        @(posedge clock); #1;
        reset = 1'b0;

        count_not_ready(n, pv);
        check("init sweep length", 32'(n), 2048);
        check("ready after init", 32'(a_ready), 1);
        check("ready after init w2", 32'(b_ready), 1);

        // Table-driven vectors, one per cycle
        for (int i = 0; i < 23; i++) begin
            @(posedge clock); #1;
            increment = vecs[i].inc; increment_address = vecs[i].ia;
            decrement = vecs[i].dec; decrement_address = vecs[i].da;
            probe = vecs[i].prb; probe_address = vecs[i].pa;
            if (vecs[i].prb) sbq.push_back('{vecs[i].e16, vecs[i].e2});
        end
        @(posedge clock); #1;
        drive_idle();
        repeat (4) @(posedge clock);
        #1;
        check("scoreboard drained", 32'(sbq.size()), 0);
        check("overflow w16", 32'(a_overflow), 0);
        check("underflow w16", 32'(a_underflow), 1);
        check("overflow w2", 32'(b_overflow), 1);
        check("underflow w2", 32'(b_underflow), 1);
        check("p_count holds", 32'(a_p_count), 2);
        check("p_valid idle", 32'(a_p_valid), 0);

        // Clear with region 9 at 2; ops presented during the sweep are dropped
        @(posedge clock); #1;
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        check("clear overflow", 32'(b_overflow), 0);
        check("clear underflow", 32'(a_underflow), 0);
        increment = 1'b1; increment_address = raddr(9);
        decrement = 1'b1; decrement_address = raddr(4);
        count_not_ready(n, pv);
        drive_idle();
        check("clear sweep length", 32'(n), 2048);
        @(posedge clock); #1;
        probe = 1'b1; probe_address = raddr(9);
        sbq.push_back('{0, 0});
        @(posedge clock); #1;
        probe = 1'b1; probe_address = raddr(4);
        sbq.push_back('{0, 0});
        @(posedge clock); #1;
        drive_idle();
        repeat (4) @(posedge clock);
        #1;
        check("clear probes drained", 32'(sbq.size()), 0);
        check("no underflow from dropped dec", 32'(a_underflow), 0);

        // Probe in cycle 0, reset in cycle 1: probe squashed, sweep restarts
        @(posedge clock); #1;
        probe = 1'b1; probe_address = raddr(0);
        @(posedge clock); #1;
        probe = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        count_not_ready(n, pv);
        check("squashed probe p_valid", 32'(pv), 0);
        check("reset sweep length", 32'(n), 2048);
        check("squash left scoreboard empty", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
